// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, header layout
// and the bytes-per-word helper.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES = 2;
  localparam int CNT_WIDTH = 16;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in the top byte,
// and word_ready flags the cycle in which the last byte of the word arrives.
module word_packer
  import prog_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_vld,
  input  logic [7:0]       byte_data,
  output logic [WIDTH-1:0] word,
  output logic             word_ready
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WIDTH-1:0] shreg_p0;
  logic [IW-1:0]    idx_p0;
  logic             last_byte;

  // word is the assembled value including the byte arriving this cycle, so the
  // caller can register it on the same edge that accepts the final byte.
  assign last_byte  = (idx_p0 == IW'(BPW - 1));
  assign word       = (shreg_p0 << 8) | WIDTH'(byte_data);
  assign word_ready = byte_vld && last_byte;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      shreg_p0 <= '0;
      idx_p0   <= '0;
    end else if (byte_vld) begin
      shreg_p0 <= word;
      idx_p0   <= last_byte ? '0 : idx_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed byte-stream image into instruction/data memory while holding
// the CPU in reset, then releases the CPU once the checksum verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                cpu_reset_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MEMSIZE = 32'd1 << ADDRSIZE;

  state_t state, state_nx;

  logic                 accept;
  logic                 launch;
  logic [7:0]           xor_acc;
  logic [7:0]           cnt_hi;
  logic [CNT_WIDTH-1:0] n_words;
  logic [CNT_WIDTH-1:0] wcount;
  logic [CNT_WIDTH-1:0] hdr_n;
  logic                 last_word;
  logic                 pk_ready;
  logic [WIDTH-1:0]     pk_word;

  logic                 vld_p1;
  logic [ADDRSIZE-1:0]  addr_p1;
  logic [WIDTH-1:0]     wdata_p1;

  assign accept    = rx_valid && rx_ready;
  assign hdr_n     = {cnt_hi, rx_data};
  assign last_word = (wcount == n_words - 1'b1);

  word_packer #(.WIDTH(WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (launch),
    .byte_vld  (accept && (state == S_DATA)),
    .byte_data (rx_data),
    .word      (pk_word),
    .word_ready(pk_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    rx_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    cpu_reset_n = 1'b0;
    launch      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        done        = (state == S_DONE);
        err         = (state == S_ERR);
        cpu_reset_n = (state == S_DONE);
        if (start) begin
          launch   = 1'b1;
          state_nx = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = S_HDR_LO;
      end
      S_HDR_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) begin
          if (32'(hdr_n) > MEMSIZE) state_nx = S_ERR;
          else if (hdr_n == '0)     state_nx = S_CSUM;
          else                      state_nx = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (pk_ready && last_word) state_nx = S_CSUM;
      end
      S_CSUM: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = (rx_data == xor_acc) ? S_DONE : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Stage p1: memory write port, one cycle after the last byte of each word.
  // wcount never advances past N-1 before use, so the address cannot wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xor_acc  <= '0;
      cnt_hi   <= '0;
      n_words  <= '0;
      wcount   <= '0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (launch) begin
        xor_acc <= '0;
        cnt_hi  <= '0;
        n_words <= '0;
        wcount  <= '0;
      end else if (accept) begin
        if (state != S_CSUM)   xor_acc <= xor_acc ^ rx_data;
        if (state == S_HDR_HI) cnt_hi  <= rx_data;
        if (state == S_HDR_LO) n_words <= hdr_n;
      end
      if (pk_ready) begin
        vld_p1   <= 1'b1;
        addr_p1  <= ADDRSIZE'(wcount);
        wdata_p1 <= pk_word;
        wcount   <= wcount + 1'b1;
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;

endmodule
